// File: rtl/fc_event_feeder.sv
// fc_event_feeder: per-source pending flags serialized as event IDs
// to the FC event FIFO with round-robin arbitration and drop counting.
module fc_event_feeder #(
    parameter int NB_EVENTS      = 32,
    parameter int EVENT_ID_WIDTH = 8,
    parameter int ID_OFFSET      = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NB_EVENTS-1:0]      events_i,
    input  logic                      enable_i,
    output logic                      event_fifo_valid_o,
    input  logic                      event_fifo_fulln_i,
    output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
    output logic [NB_EVENTS-1:0]      pending_o,
    output logic                      overflow_o,
    output logic [15:0]               drop_count_o,
    input  logic                      drop_clr_i
);
    localparam int PW = (NB_EVENTS > 1) ? $clog2(NB_EVENTS) : 1;
    localparam int CW = $clog2(NB_EVENTS + 1);

    typedef enum logic {IDLE, VALID} state_t;

    state_t                  state;
    logic [NB_EVENTS-1:0]    pending;
    logic [NB_EVENTS-1:0]    sel_mask;
    logic [NB_EVENTS-1:0]    drop;
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           win;
    logic [PW-1:0]           ptr_next;
    logic [EVENT_ID_WIDTH-1:0] data;
    logic                    found;
    logic                    transfer;
    logic                    load_slot;
    logic                    grant;
    logic                    overflow;
    logic [15:0]             drop_count;
    logic [CW-1:0]           drop_num;
    logic [16:0]             drop_sum;
    int                      idx;

    assign transfer  = (state == VALID) && event_fifo_fulln_i;
    assign load_slot = (state == IDLE) || transfer;
    assign grant     = enable_i && load_slot && found;

    // Scan from the pointer upward, wrapping without needing a power of two.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NB_EVENTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NB_EVENTS) idx = idx - NB_EVENTS;
            if (!found && pending[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign sel_mask = grant ? (NB_EVENTS'(1) << win) : '0;
    assign drop     = events_i & pending & ~sel_mask;
    assign ptr_next = (int'(win) == NB_EVENTS - 1) ? '0 : win + 1'b1;

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NB_EVENTS; i++) begin
            drop_num = drop_num + CW'(drop[i]);
        end
    end

    assign drop_sum = (drop_clr_i ? 17'd0 : {1'b0, drop_count}) + 17'(drop_num);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            data       <= '0;
            ptr        <= '0;
            pending    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            pending    <= (pending & ~sel_mask) | events_i;
            overflow   <= |drop;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        state <= VALID;
                        data  <= EVENT_ID_WIDTH'(ID_OFFSET + int'(win));
                        ptr   <= ptr_next;
                    end
                end
                VALID: begin
                    if (grant) begin
                        data <= EVENT_ID_WIDTH'(ID_OFFSET + int'(win));
                        ptr  <= ptr_next;
                    end else if (transfer) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign event_fifo_valid_o = (state == VALID);
    assign event_fifo_data_o  = data;
    assign pending_o          = pending;
    assign overflow_o         = overflow;
    assign drop_count_o       = drop_count;
endmodule
